reservation_station: RTL and testbench

// - Per-unit Tomasulo reservation station downstream of the dispatcher (add_sub/mul/div/log/rot/cmp/sys/trap).
// - Buffers dispatched ops with operand values or producer tags; snoops the result bus; issues ready ops to the unit.
// - Publishes the RS id of the next free entry; this id is what the dispatcher returns as id_taken.

---
 rtl/reservation_station_pkg.sv | 21 ++
 rtl/reservation_station_select.sv | 54 +++++
 rtl/reservation_station.sv | 199 +++++++++++++++++++
 tb/tb_reservation_station.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reservation_station_pkg.sv
// Shared types and constants for the reservation station and its picker.
// Optional feature macro used by the importers: RS_OLDEST_FIRST_EN.
package reservation_station_pkg;

  localparam int RS_ID_WIDTH_DEF = 5;

  // Tag value meaning "no producer, value already valid".
  localparam logic [RS_ID_WIDTH_DEF-1:0] RS_TAG_NONE = '0;

  typedef struct packed {
    logic                         valid;
    logic [0:31]                  value;
    logic [0:RS_ID_WIDTH_DEF-1]   rs_id;
  } rs_operand_t;

  // Entry index width; a single-entry station still needs one bit.
  function automatic int rs_idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/reservation_station_select.sv
// Picks one requester: lowest index by default, or the largest age when
// RS_OLDEST_FIRST_EN is defined. Returns a one-hot grant and its index.
module rs_select
  import reservation_station_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
`ifdef RS_OLDEST_FIRST_EN
  input  logic [IW-1:0] i_age [N],
`endif
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

`ifdef RS_OLDEST_FIRST_EN
  logic [IW-1:0] w_best_age;

  // Ages of valid entries are distinct, so the strict compare never ties.
  always_comb begin
    o_idx      = '0;
    o_any      = 1'b0;
    w_best_age = '0;
    for (int i = 0; i < N; i++) begin
      if (i_req[i] && (!o_any || (i_age[i] > w_best_age))) begin
        o_any      = 1'b1;
        o_idx      = IW'(i);
        w_best_age = i_age[i];
      end
    end
  end
`else
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_any = 1'b1;
        o_idx = IW'(i);
      end
    end
  end
`endif

  always_comb begin
    o_grant = '0;
    for (int i = 0; i < N; i++) begin
      o_grant[i] = o_any && (o_idx == IW'(i));
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Tomasulo reservation station: buffers ops, snoops the result bus, issues
// ready ops to the unit. RS_OLDEST_FIRST_EN selects oldest-ready issue order.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int  RS_ID_WIDTH = RS_ID_WIDTH_DEF,
  parameter int  RS_OFFSET   = 1,
  parameter int  RS_DEPTH    = 4,
  parameter int  OPERANDS    = 3,
  parameter type OPERATION_T = logic
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 input_valid,
  output logic                                 input_ready,
  input  OPERATION_T                           operation_in,
  input  logic [OPERANDS-1:0]                  op_value_valid,
  input  logic [OPERANDS-1:0][0:31]            op_value,
  input  logic [OPERANDS-1:0][RS_ID_WIDTH-1:0] op_rs_id,
  output logic [RS_ID_WIDTH-1:0]               id,
  input  logic                                 result_valid,
  input  logic [RS_ID_WIDTH-1:0]               result_rs_id,
  input  logic [0:31]                          result_value,
  output logic                                 operation_valid,
  input  logic                                 operation_ready,
  output OPERATION_T                           operation_out,
  output logic [OPERANDS-1:0][0:31]            op_value_out,
  output logic [RS_ID_WIDTH-1:0]               op_rs_id_out
);

  localparam int IW = rs_idx_width(RS_DEPTH);

  logic [RS_DEPTH-1:0]                  r_valid;
  OPERATION_T                           r_op  [RS_DEPTH];
  logic [OPERANDS-1:0]                  r_opv [RS_DEPTH];
  logic [OPERANDS-1:0][0:31]            r_val [RS_DEPTH];
  logic [OPERANDS-1:0][RS_ID_WIDTH-1:0] r_tag [RS_DEPTH];
  logic                                 r_lock;
  logic [IW-1:0]                        r_lock_idx;

  logic                w_bcast;
  logic                w_any_free;
  logic [IW-1:0]       w_alloc_idx;
  logic                w_alloc;
  logic [RS_DEPTH-1:0] w_ready;
  logic [RS_DEPTH-1:0] w_grant;
  logic [IW-1:0]       w_pick_idx;
  logic                w_pick_any;
  logic [RS_DEPTH-1:0] w_lock_oh;
  logic [RS_DEPTH-1:0] w_sel_oh;
  logic [IW-1:0]       w_sel_idx;
  logic                w_issue_valid;
  logic                w_fire;

  assign w_bcast = result_valid && (result_rs_id != RS_ID_WIDTH'(RS_TAG_NONE));

  always_comb begin
    w_alloc_idx = '0;
    w_any_free  = 1'b0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_alloc_idx = IW'(i);
        w_any_free  = 1'b1;
      end
    end
  end

  assign input_ready = w_any_free;
  assign id          = w_any_free ? RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(w_alloc_idx) : '0;
  assign w_alloc     = input_valid && w_any_free;

  always_comb begin
    w_ready = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      w_ready[i] = r_valid[i] && (&r_opv[i]);
    end
  end

`ifdef RS_OLDEST_FIRST_EN
  // Age = number of still-resident entries allocated after this one.
  logic [IW-1:0] r_age     [RS_DEPTH];
  logic [IW-1:0] w_age_nxt [RS_DEPTH];

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      w_age_nxt[i] = r_age[i];
      if (w_fire && (r_age[i] > r_age[w_sel_idx])) begin
        w_age_nxt[i] = w_age_nxt[i] - 1'b1;
      end
      if (w_alloc) begin
        w_age_nxt[i] = w_age_nxt[i] + 1'b1;
      end
      if (w_alloc && (w_alloc_idx == IW'(i))) begin
        w_age_nxt[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RS_DEPTH; i++) r_age[i] <= '0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (r_valid[i] || (w_alloc && (w_alloc_idx == IW'(i)))) begin
          r_age[i] <= w_age_nxt[i];
        end
      end
    end
  end

  rs_select #(.N(RS_DEPTH), .IW(IW)) u_select (
    .i_req   (w_ready),
    .i_age   (r_age),
    .o_grant (w_grant),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );
`else
  rs_select #(.N(RS_DEPTH), .IW(IW)) u_select (
    .i_req   (w_ready),
    .o_grant (w_grant),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );
`endif

  always_comb begin
    w_lock_oh = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      w_lock_oh[i] = (r_lock_idx == IW'(i));
    end
  end

  // A stalled issue stays on the entry it first offered.
  assign w_sel_oh      = r_lock ? w_lock_oh : w_grant;
  assign w_sel_idx     = r_lock ? r_lock_idx : w_pick_idx;
  assign w_issue_valid = r_lock || w_pick_any;
  assign w_fire        = w_issue_valid && operation_ready;

  assign operation_valid = w_issue_valid;
  assign operation_out   = w_issue_valid ? r_op[w_sel_idx]  : '0;
  assign op_value_out    = w_issue_valid ? r_val[w_sel_idx] : '0;
  assign op_rs_id_out    = w_issue_valid ? RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(w_sel_idx) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
    end else if (w_issue_valid && !operation_ready) begin
      r_lock     <= 1'b1;
      r_lock_idx <= w_sel_idx;
    end else if (w_fire) begin
      r_lock     <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        r_op[i]  <= '0;
        r_opv[i] <= '0;
        r_val[i] <= '0;
        r_tag[i] <= '0;
      end
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        for (int k = 0; k < OPERANDS; k++) begin
          if (r_valid[i] && !r_opv[i][k] && w_bcast && (r_tag[i][k] == result_rs_id)) begin
            r_opv[i][k] <= 1'b1;
            r_val[i][k] <= result_value;
          end
        end
        if (w_fire && w_sel_oh[i]) begin
          r_valid[i] <= 1'b0;
        end
        // Allocation only targets a free slot, so it never collides with the freed one.
        if (w_alloc && (w_alloc_idx == IW'(i))) begin
          r_valid[i] <= 1'b1;
          r_op[i]    <= operation_in;
          for (int k = 0; k < OPERANDS; k++) begin
            r_tag[i][k] <= op_rs_id[k];
            if (op_value_valid[k]) begin
              r_opv[i][k] <= 1'b1;
              r_val[i][k] <= op_value[k];
            end else if (w_bcast && (op_rs_id[k] == result_rs_id)) begin
              r_opv[i][k] <= 1'b1;
              r_val[i][k] <= result_value;
            end else begin
              r_opv[i][k] <= 1'b0;
              r_val[i][k] <= '0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station (4 entries, tag offset 1, 3 operands).
module tb_reservation_station;

  logic            clk;
  logic            rst_n;
  logic            input_valid;
  logic            input_ready;
  logic [7:0]      operation_in;
  logic [2:0]      op_value_valid;
  logic [2:0][0:31] op_value;
  logic [2:0][4:0] op_rs_id;
  logic [4:0]      id;
  logic            result_valid;
  logic [4:0]      result_rs_id;
  logic [0:31]     result_value;
  logic            operation_valid;
  logic            operation_ready;
  logic [7:0]      operation_out;
  logic [2:0][0:31] op_value_out;
  logic [4:0]      op_rs_id_out;

  int checks   = 0;
  int failures = 0;

  reservation_station #(
    .RS_ID_WIDTH (5),
    .RS_OFFSET   (1),
    .RS_DEPTH    (4),
    .OPERANDS    (3),
    .OPERATION_T (logic [7:0])
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .input_valid     (input_valid),
    .input_ready     (input_ready),
    .operation_in    (operation_in),
    .op_value_valid  (op_value_valid),
    .op_value        (op_value),
    .op_rs_id        (op_rs_id),
    .id              (id),
    .result_valid    (result_valid),
    .result_rs_id    (result_rs_id),
    .result_value    (result_value),
    .operation_valid (operation_valid),
    .operation_ready (operation_ready),
    .operation_out   (operation_out),
    .op_value_out    (op_value_out),
    .op_rs_id_out    (op_rs_id_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    input_valid    = 1'b0;
    operation_in   = '0;
    op_value_valid = '0;
    op_value       = '0;
    op_rs_id       = '0;
    result_valid   = 1'b0;
    result_rs_id   = '0;
    result_value   = '0;
  endtask

  task automatic drive_alloc(input logic [7:0] op, input logic [2:0] vv,
                             input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2,
                             input logic [4:0] t0, input logic [4:0] t1, input logic [4:0] t2);
    input_valid    = 1'b1;
    operation_in   = op;
    op_value_valid = vv;
    op_value[0]    = v0;
    op_value[1]    = v1;
    op_value[2]    = v2;
    op_rs_id[0]    = t0;
    op_rs_id[1]    = t1;
    op_rs_id[2]    = t2;
  endtask

  task automatic drive_bcast(input logic [4:0] tag, input logic [31:0] val);
    result_valid = 1'b1;
    result_rs_id = tag;
    result_value = val;
  endtask

  initial begin
    idle_inputs();
    operation_ready = 1'b0;
    rst_n = 1'b0;
    #22;
    chk("rst_input_ready", input_ready, 1);
    chk("rst_id", id, 1);
    chk("rst_op_valid", operation_valid, 0);
    chk("rst_op_out", operation_out, 0);
    chk("rst_rs_id_out", op_rs_id_out, 0);
    chk("rst_value_out", op_value_out, 0);
    rst_n = 1'b1;
    step();

    // all operands valid: issues the cycle after allocation
    drive_alloc(8'h11, 3'b111, 32'h1, 32'h2, 32'h3, 5'd0, 5'd0, 5'd0);
    #1 chk("t1_id_before", id, 1);
    step();
    idle_inputs();
    #1;
    chk("t1_id_after", id, 2);
    chk("t1_op_valid", operation_valid, 1);
    chk("t1_op_out", operation_out, 8'h11);
    chk("t1_val0", op_value_out[0], 32'h1);
    chk("t1_val2", op_value_out[2], 32'h3);
    chk("t1_rs_id_out", op_rs_id_out, 1);
    operation_ready = 1'b1;
    step();
    operation_ready = 1'b0;
    #1;
    chk("t1_freed_valid", operation_valid, 0);
    chk("t1_freed_id", id, 1);

    // src0 waits on tag 3
    drive_alloc(8'h22, 3'b110, 32'h0, 32'h5, 32'h6, 5'd3, 5'd0, 5'd0);
    step();
    idle_inputs();
    #1 chk("t2_waiting", operation_valid, 0);
    drive_bcast(5'd3, 32'hDEADBEEF);
    step();
    idle_inputs();
    #1;
    chk("t2_valid", operation_valid, 1);
    chk("t2_val0", op_value_out[0], 32'hDEADBEEF);
    chk("t2_val1", op_value_out[1], 32'h5);
    operation_ready = 1'b1;
    step();
    operation_ready = 1'b0;

    // same-cycle forward of tag 5 into src1
    drive_alloc(8'h33, 3'b101, 32'h7, 32'h0, 32'h9, 5'd0, 5'd5, 5'd0);
    drive_bcast(5'd5, 32'hCAFEF00D);
    step();
    idle_inputs();
    #1;
    chk("t3_valid", operation_valid, 1);
    chk("t3_val1", op_value_out[1], 32'hCAFEF00D);
    chk("t3_op_out", operation_out, 8'h33);
    operation_ready = 1'b1;
    step();
    operation_ready = 1'b0;

    // fill: slot0 waits tag 7, slots 1..3 wait tag 8
    for (int i = 0; i < 4; i++) begin
      drive_alloc(8'h40 + 8'(i), 3'b110, 32'h0, 32'h1, 32'h2,
                  (i == 0) ? 5'd7 : 5'd8, 5'd0, 5'd0);
      #1 chk("t4_fill_id", id, 64'(i + 1));
      step();
    end
    drive_alloc(8'h99, 3'b111, 32'h1, 32'h1, 32'h1, 5'd0, 5'd0, 5'd0);
    #1;
    chk("t4_full_ready", input_ready, 0);
    chk("t4_full_id", id, 0);
    chk("t4_full_no_issue", operation_valid, 0);
    step();
    idle_inputs();
    #1 chk("t4_still_full", input_ready, 0);
    drive_bcast(5'd8, 32'h88);
    step();
    idle_inputs();
    #1;
    chk("t4_issue_rs_id", op_rs_id_out, 2);
    chk("t4_issue_op", operation_out, 8'h41);
    chk("t4_issue_val0", op_value_out[0], 32'h88);
    drive_bcast(5'd7, 32'h77);
    step();
    idle_inputs();
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t4_stall_rs_id", op_rs_id_out, 2);
      chk("t4_stall_op", operation_out, 8'h41);
      chk("t4_stall_valid", operation_valid, 1);
      step();
    end
    operation_ready = 1'b1;
    step();
    #1;
    chk("t4_freed_ready", input_ready, 1);
    chk("t4_freed_id", id, 2);
    chk("t4_next_rs_id", op_rs_id_out, 1);
    chk("t4_next_op", operation_out, 8'h40);
    chk("t4_next_val0", op_value_out[0], 32'h77);
    step();
    #1;
    chk("t4_drain2_rs_id", op_rs_id_out, 3);
    chk("t4_drain2_op", operation_out, 8'h42);
    chk("t4_drain2_id", id, 1);
    step();
    #1 chk("t4_drain3_rs_id", op_rs_id_out, 4);
    step();
    #1 chk("t4_drained", operation_valid, 0);
    operation_ready = 1'b0;

    // A waits (slot0), B and C ready: B before C, A after broadcast
    drive_alloc(8'hA0, 3'b110, 32'h0, 32'h1, 32'h2, 5'd9, 5'd0, 5'd0);
    step();
    drive_alloc(8'hB0, 3'b111, 32'h1, 32'h1, 32'h1, 5'd0, 5'd0, 5'd0);
    #1 chk("t5_id_b", id, 2);
    step();
    drive_alloc(8'hC0, 3'b111, 32'h2, 32'h2, 32'h2, 5'd0, 5'd0, 5'd0);
    #1 chk("t5_id_c", id, 3);
    step();
    idle_inputs();
    #1;
    chk("t5_first_rs_id", op_rs_id_out, 2);
    chk("t5_first_op", operation_out, 8'hB0);
    operation_ready = 1'b1;
    step();
    #1 chk("t5_second_op", operation_out, 8'hC0);
    step();
    #1 chk("t5_a_waiting", operation_valid, 0);
    operation_ready = 1'b0;
    drive_bcast(5'd9, 32'h12345678);
    step();
    idle_inputs();
    #1;
    chk("t5_a_op", operation_out, 8'hA0);
    chk("t5_a_rs_id", op_rs_id_out, 1);
    chk("t5_a_val0", op_value_out[0], 32'h12345678);
    step();

    // reset while stalled
    rst_n = 1'b0;
    #1;
    chk("t6_rst_op_valid", operation_valid, 0);
    chk("t6_rst_op_out", operation_out, 0);
    chk("t6_rst_rs_id_out", op_rs_id_out, 0);
    chk("t6_rst_id", id, 1);
    chk("t6_rst_ready", input_ready, 1);
    #2 rst_n = 1'b1;
    step();

    // younger entry in a lower slot than older ready entries
    drive_alloc(8'h50, 3'b111, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    step();
    drive_alloc(8'h51, 3'b110, 32'h0, 32'h0, 32'h0, 5'd12, 5'd0, 5'd0);
    step();
    drive_alloc(8'h52, 3'b110, 32'h0, 32'h0, 32'h0, 5'd12, 5'd0, 5'd0);
    step();
    idle_inputs();
    operation_ready = 1'b1;
    step();
    operation_ready = 1'b0;
    drive_alloc(8'h53, 3'b110, 32'h0, 32'h0, 32'h0, 5'd12, 5'd0, 5'd0);
    #1 chk("t7_id_s", id, 1);
    step();
    idle_inputs();
    drive_bcast(5'd12, 32'hC);
    step();
    idle_inputs();
    #1;
`ifdef RS_OLDEST_FIRST_EN
    chk("t7_pick_rs_id", op_rs_id_out, 2);
    chk("t7_pick_op", operation_out, 8'h51);
`else
    chk("t7_pick_rs_id", op_rs_id_out, 1);
    chk("t7_pick_op", operation_out, 8'h53);
`endif
    operation_ready = 1'b1;
    step();
    step();
    step();
    operation_ready = 1'b0;
    #1 chk("t7_drained", operation_valid, 0);

    // broadcast on tag 0 must not wake an operand stored with tag 0
    drive_alloc(8'h60, 3'b110, 32'h0, 32'h1, 32'h1, 5'd0, 5'd0, 5'd0);
    drive_bcast(5'd0, 32'h55);
    step();
    idle_inputs();
    drive_bcast(5'd0, 32'h66);
    step();
    idle_inputs();
    #1 chk("t8_tag0_ignored", operation_valid, 0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
